spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 target: 16-bit write frames into five 8-bit control registers.
// Define SPI_READBACK_EN to enable register readback on cipo_o during read frames.
module spi_reg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output logic       cipo_o,
  output logic [7:0] en_reg_out_7_0_o,
  output logic [7:0] en_reg_out_15_8_o,
  output logic [7:0] en_reg_pwm_7_0_o,
  output logic [7:0] en_reg_pwm_15_8_o,
  output logic [7:0] pwm_duty_cycle_o,
  output logic       wr_done_o
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_e         state_q;
  logic [4:0]     cnt_q;
  logic [15:0]    shreg_q;
  logic [15:0]    shreg_shift;
  logic [4:0][7:0] regs_q;
  logic           wr_done_q;
  logic [6:0]     wr_addr;
  logic           wr_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_dly_q;
  assign ncs_rise    = ncs_s & ~ncs_dly_q;
  assign ncs_fall    = ~ncs_s & ncs_dly_q;
  assign shreg_shift = {shreg_q[14:0], copi_s};
  assign wr_addr     = shreg_q[14:8];
  assign wr_hit      = (cnt_q == 5'd16) && shreg_q[15] && (wr_addr <= MAX_ADDR);

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] out_sh_q;
  logic [7:0] rd_data;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  // At the 8th rising edge shreg_shift[6:0] already holds the full read address.
  always_comb begin
    rd_data = 8'h00;
    if (shreg_shift[6:0] <= MAX_ADDR) begin
      case (shreg_shift[6:0])
        7'h00:   rd_data = regs_q[0];
        7'h01:   rd_data = regs_q[1];
        7'h02:   rd_data = regs_q[2];
        7'h03:   rd_data = regs_q[3];
        7'h04:   rd_data = regs_q[4];
        default: rd_data = 8'h00;
      endcase
    end
  end

  assign cipo_o = out_sh_q[7];
`else
  assign cipo_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      regs_q    <= '0;
      wr_done_q <= 1'b0;
`ifdef SPI_READBACK_EN
      out_sh_q  <= '0;
`endif
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q <= StShift;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        StShift: begin
          if (ncs_rise) begin
            // An sclk edge coinciding with deselect is dropped.
            state_q <= StCommit;
`ifdef SPI_READBACK_EN
            out_sh_q <= '0;
`endif
          end else begin
            if (sclk_rise) begin
              shreg_q <= shreg_shift;
              if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
`ifdef SPI_READBACK_EN
              if (cnt_q == 5'd7 && !shreg_shift[7]) out_sh_q <= rd_data;
`endif
            end
`ifdef SPI_READBACK_EN
            // The falling edge right after the load keeps the MSB on the line.
            if (sclk_fall && cnt_q >= 5'd9) out_sh_q <= {out_sh_q[6:0], 1'b0};
`endif
          end
        end
        StCommit: begin
          if (wr_hit) begin
            wr_done_q <= 1'b1;
            case (wr_addr)
              7'h00:   regs_q[0] <= shreg_q[7:0];
              7'h01:   regs_q[1] <= shreg_q[7:0];
              7'h02:   regs_q[2] <= shreg_q[7:0];
              7'h03:   regs_q[3] <= shreg_q[7:0];
              7'h04:   regs_q[4] <= shreg_q[7:0];
              default: ;
            endcase
          end
          // A reselect seen here starts the next frame without passing through idle.
          if (ncs_fall) begin
            state_q <= StShift;
            cnt_q   <= '0;
            shreg_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_reg_out_7_0_o  = regs_q[0];
  assign en_reg_out_15_8_o = regs_q[1];
  assign en_reg_pwm_7_0_o  = regs_q[2];
  assign en_reg_pwm_15_8_o = regs_q[3];
  assign pwm_duty_cycle_o  = regs_q[4];
  assign wr_done_o         = wr_done_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl (default SYNC_STAGES = 2, MAX_ADDR = 4).
module tb_spi_reg_ctrl;

  localparam int HALF = 6;  // clk cycles per sclk half-period
  localparam int LAT  = 4;  // 2 sync stages + edge-to-COMMIT + COMMIT-to-write

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, wr_done;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic [39:0] all_regs;
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sclk_i            (sclk),
    .copi_i            (copi),
    .ncs_i             (ncs),
    .cipo_o            (cipo),
    .en_reg_out_7_0_o  (out_lo),
    .en_reg_out_15_8_o (out_hi),
    .en_reg_pwm_7_0_o  (pwm_lo),
    .en_reg_pwm_15_8_o (pwm_hi),
    .pwm_duty_cycle_o  (duty),
    .wr_done_o         (wr_done)
  );

  assign all_regs = {duty, pwm_hi, pwm_lo, out_hi, out_lo};

  always @(posedge clk) if (wr_done === 1'b1) wr_cnt++;

  // Shifts word[nbits-1:0] MSB first; rx collects cipo just before each rising sclk.
  task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[30:0], cipo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [31:0] rx);
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(word, nbits, rx);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (all_regs !== 40'h0) begin
      n_err++; $display("FAIL reset_regs: got %h want %h", all_regs, 40'h0);
    end
    n_vec++;
    if (wr_done !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_done: got %b want 0", wr_done);
    end
    n_vec++;
    if (cipo !== 1'b0) begin
      n_err++; $display("FAIL reset_cipo: got %b want 0", cipo);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    logic [31:0] rx;
    int first = 0;
    int pulses = 0;
    logic [7:0] duty_pre = 8'hxx;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(32'h84A5, 16, rx);
    ncs = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == LAT - 1) duty_pre = duty;
      if (wr_done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    n_vec++;
    if (first != LAT) begin
      n_err++; $display("FAIL write_latency: got %0d want %0d", first, LAT);
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL write_pulses: got %0d want 1", pulses);
    end
    n_vec++;
    if (duty_pre !== 8'h00) begin
      n_err++; $display("FAIL write_early: got %h want 00", duty_pre);
    end
    n_vec++;
    if (all_regs !== 40'hA5_00_00_00_00) begin
      n_err++; $display("FAIL write_regs: got %h want %h", all_regs, 40'hA5_00_00_00_00);
    end
  endtask

  task automatic test_bad_frames;
    logic [31:0] words [4] = '{32'h4119, 32'h10466, 32'h8533, 32'h0233};
    int          lens  [4] = '{15, 17, 16, 16};
    logic [31:0] rx;
    int c0;
    for (int i = 0; i < 4; i++) begin
      c0 = wr_cnt;
      spi_frame(words[i], lens[i], rx);
      n_vec++;
      if (wr_cnt != c0) begin
        n_err++; $display("FAIL bad_frame_wr_done[%0d]: got %0d pulses want 0", i, wr_cnt - c0);
      end
      n_vec++;
      if (all_regs !== 40'hA5_00_00_00_00) begin
        n_err++;
        $display("FAIL bad_frame_regs[%0d]: got %h want %h", i, all_regs, 40'hA5_00_00_00_00);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rx;
    int c0;
    c0 = wr_cnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(32'h103, 9, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spi_bits(32'h7F, 7, rx);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (all_regs !== 40'h0) begin
      n_err++; $display("FAIL midreset_regs: got %h want %h", all_regs, 40'h0);
    end
    n_vec++;
    if (wr_cnt != c0) begin
      n_err++; $display("FAIL midreset_wr_done: got %0d pulses want 0", wr_cnt - c0);
    end
    spi_frame(32'h81FF, 16, rx);
    n_vec++;
    if (all_regs !== 40'h00_00_00_FF_00) begin
      n_err++; $display("FAIL midreset_refill: got %h want %h", all_regs, 40'h00_00_00_FF_00);
    end
  endtask

  task automatic test_sclk_ncs_high;
    logic [31:0] rx;
    int c0;
    c0 = wr_cnt;
    spi_bits(32'hFFFF, 16, rx);
    repeat (10) @(negedge clk);
    n_vec++;
    if (wr_cnt != c0 || all_regs !== 40'h00_00_00_FF_00) begin
      n_err++;
      $display("FAIL idle_sclk: got %h/%0d want %h/0", all_regs, wr_cnt - c0, 40'h00_00_00_FF_00);
    end
    spi_frame(32'h8003, 16, rx);
    n_vec++;
    if (all_regs !== 40'h00_00_00_FF_03) begin
      n_err++; $display("FAIL idle_sclk_write: got %h want %h", all_regs, 40'h00_00_00_FF_03);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx;
    int c0;
    c0 = wr_cnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(32'h8011, 16, rx);
    ncs = 1'b1;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(32'h8322, 16, rx);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (all_regs !== 40'h00_22_00_FF_11) begin
      n_err++; $display("FAIL b2b_regs: got %h want %h", all_regs, 40'h00_22_00_FF_11);
    end
    n_vec++;
    if (wr_cnt - c0 != 2) begin
      n_err++; $display("FAIL b2b_wr_done: got %0d pulses want 2", wr_cnt - c0);
    end
  endtask

  task automatic test_readback;
    logic [31:0] rx;
    logic [15:0] exp_rd;
    int c0;
`ifdef SPI_READBACK_EN
    exp_rd = 16'h005A;
`else
    exp_rd = 16'h0000;
`endif
    spi_frame(32'h835A, 16, rx);
    c0 = wr_cnt;
    spi_frame(32'h0300, 16, rx);
    n_vec++;
    if (rx[15:0] !== exp_rd) begin
      n_err++; $display("FAIL read_addr3: got %h want %h", rx[15:0], exp_rd);
    end
    spi_frame(32'h0600, 16, rx);
    n_vec++;
    if (rx[15:0] !== 16'h0000) begin
      n_err++; $display("FAIL read_addr6: got %h want 0000", rx[15:0]);
    end
    n_vec++;
    if (wr_cnt != c0 || cipo !== 1'b0) begin
      n_err++; $display("FAIL read_side_effects: got %0d pulses cipo %b want 0/0", wr_cnt - c0, cipo);
    end
    n_vec++;
    if (all_regs !== 40'h00_5A_00_FF_11) begin
      n_err++; $display("FAIL read_regs: got %h want %h", all_regs, 40'h00_5A_00_FF_11);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_frames();
    test_reset_midframe();
    test_sclk_ncs_high();
    test_back_to_back();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
